sync_fifo_ctrl: RTL and testbench

- Generic synchronous FIFO in plain RTL. Replaces vendor-generated single-clock FIFO wrappers such as the address-store FIFO.
- Width and depth are parametrised.
- Selectable standard or first-word-fall-through (FWFT) read mode.
- Almost-full/almost-empty thresholds are programmable at run time. The block also provides a synchronous flush and sticky overflow/underflow error flags for the address/pixel queues of the video pipeline.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/sync_fifo_ram.sv | 23 ++
 rtl/sync_fifo_ctrl.sv | 142 ++++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO controller and its RAM.
package fifo_pkg;

  localparam int unsigned MODE_STD  = 0;
  localparam int unsigned MODE_FWFT = 1;

  // Level and threshold width: one extra bit so a completely full FIFO is representable.
  function automatic int unsigned level_width(input int unsigned depth_width);
    return depth_width + 1;
  endfunction

  // Reduces a threshold to the level width, dropping bits the comparators cannot see.
  function automatic int unsigned thr_clamp(input int unsigned value,
                                            input int unsigned depth_width);
    return value & ((32'd1 << (depth_width + 1)) - 32'd1);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
module sync_fifo_ram #(
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned DEPTH_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [DEPTH_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic                   re,
  input  logic [DEPTH_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]  rdata
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_WIDTH];

  // NOTE: the array and its read register carry no reset so the tools can map them onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointers, level, registered flags, thresholds and the optional FWFT prefetch.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned DEPTH_WIDTH = 11,
  parameter int unsigned FWFT        = 0,
  parameter int unsigned AF_RESET    = 1020,
  parameter int unsigned AE_RESET    = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 wr_en,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  output logic                                 wr_full,
  output logic                                 almost_full,
  output logic [level_width(DEPTH_WIDTH)-1:0]  wr_water_level,
  input  logic                                 rd_en,
  output logic [DATA_WIDTH-1:0]                rd_data,
  output logic                                 rd_empty,
  output logic                                 almost_empty,
  input  logic                                 thr_we,
  input  logic [level_width(DEPTH_WIDTH)-1:0]  af_thr_in,
  input  logic [level_width(DEPTH_WIDTH)-1:0]  ae_thr_in,
  output logic                                 overflow,
  output logic                                 underflow
);

  localparam int unsigned    LW      = level_width(DEPTH_WIDTH);
  localparam logic [LW-1:0]  DEPTH_L = LW'(2**DEPTH_WIDTH);
  localparam bit             IS_FWFT = (FWFT == MODE_FWFT);

  // Pointers carry a wrap bit so RAM occupancy is simply wr_ptr - rd_ptr.
  logic [LW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level, level_nxt;
  logic [LW-1:0]         af_thr, ae_thr, af_nxt, ae_nxt;
  logic                  wr_acc, rd_acc, ram_re, move;
  logic                  q_valid, out_valid, loaded, empty_q;
  logic [DATA_WIDTH-1:0] ram_q, out_data;

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_WIDTH(DEPTH_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr[DEPTH_WIDTH-1:0]),
    .wdata(wr_data),
    .re   (ram_re),
    .raddr(rd_ptr[DEPTH_WIDTH-1:0]),
    .rdata(ram_q)
  );

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    wr_acc    = 1'b0;
    rd_acc    = 1'b0;
    move      = 1'b0;
    ram_re    = 1'b0;
    level_nxt = level;
    af_nxt    = thr_we ? af_thr_in : af_thr;
    ae_nxt    = thr_we ? ae_thr_in : ae_thr;

    if (!flush) begin
      wr_acc = wr_en && !wr_full;
      rd_acc = rd_en && !rd_empty;
    end

    if (IS_FWFT) begin
      // RAM output register is a second prefetch stage; refill it whenever it frees up.
      move   = q_valid && (!out_valid || rd_acc);
      ram_re = !flush && (wr_ptr != rd_ptr) && (!q_valid || move);
    end else begin
      ram_re = rd_acc;
    end

    if (flush) begin
      level_nxt = '0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   level_nxt = level + LW'(1);
        2'b01:   level_nxt = level - LW'(1);
        default: level_nxt = level;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      wr_full      <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      empty_q      <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      q_valid      <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      loaded       <= 1'b0;
      af_thr       <= LW'(thr_clamp(AF_RESET, DEPTH_WIDTH));
      ae_thr       <= LW'(thr_clamp(AE_RESET, DEPTH_WIDTH));
    end else begin
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        q_valid   <= 1'b0;
        out_valid <= 1'b0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + LW'(1);
        if (ram_re) rd_ptr <= rd_ptr + LW'(1);
        if (wr_en && wr_full)  overflow  <= 1'b1;
        if (rd_en && rd_empty) underflow <= 1'b1;
        if (ram_re)    q_valid <= 1'b1;
        else if (move) q_valid <= 1'b0;
        if (move)        out_valid <= 1'b1;
        else if (rd_acc) out_valid <= 1'b0;
        if (move) out_data <= ram_q;
        if (!IS_FWFT && rd_acc) loaded <= 1'b1;
      end
      level        <= level_nxt;
      wr_full      <= (level_nxt == DEPTH_L);
      almost_full  <= (level_nxt >= af_nxt);
      almost_empty <= (level_nxt <= ae_nxt);
      empty_q      <= (level_nxt == '0);
      af_thr       <= af_nxt;
      ae_thr       <= ae_nxt;
    end
  end

  // Standard mode shows zero until the first read has actually loaded the RAM register.
  assign rd_empty       = IS_FWFT ? !out_valid : empty_q;
  assign rd_data        = IS_FWFT ? out_data : (loaded ? ram_q : '0);
  assign wr_water_level = level;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench: a standard-mode and an FWFT instance share stimulus; a scoreboard tracks the standard one.
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0, thr_we = 1'b0;
  logic [3:0] wr_data = '0;
  logic [4:0] af_thr_in = '0, ae_thr_in = '0;

  logic       s_full, s_af, s_empty, s_ae, s_ovf, s_unf;
  logic [4:0] s_level;
  logic [3:0] s_rd_data;
  logic       f_full, f_af, f_empty, f_ae, f_ovf, f_unf;
  logic [4:0] f_level;
  logic [3:0] f_rd_data;

  int         n_cmp = 0, n_err = 0;
  int         m_lvl;
  logic [4:0] m_af, m_ae;
  logic       m_ovf, m_unf;
  logic [3:0] m_rd;
  logic [3:0] sb[$];

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.DATA_WIDTH(4), .DEPTH_WIDTH(4), .FWFT(0), .AF_RESET(14), .AE_RESET(2)) dut_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(s_full), .almost_full(s_af), .wr_water_level(s_level),
    .rd_en(rd_en), .rd_data(s_rd_data), .rd_empty(s_empty), .almost_empty(s_ae),
    .thr_we(thr_we), .af_thr_in(af_thr_in), .ae_thr_in(ae_thr_in),
    .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_ctrl #(.DATA_WIDTH(4), .DEPTH_WIDTH(4), .FWFT(1), .AF_RESET(14), .AE_RESET(2)) dut_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(f_full), .almost_full(f_af), .wr_water_level(f_level),
    .rd_en(rd_en), .rd_data(f_rd_data), .rd_empty(f_empty), .almost_empty(f_ae),
    .thr_we(thr_we), .af_thr_in(af_thr_in), .ae_thr_in(ae_thr_in),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lvl = 0;
    sb.delete();
    m_af  = 5'd14;
    m_ae  = 5'd2;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rd  = 4'h0;
  endtask

  task automatic check_std();
    check("level",        32'(s_level), 32'(m_lvl));
    check("wr_full",      32'(s_full),  32'(m_lvl == 16));
    check("almost_full",  32'(s_af),    32'(m_lvl >= int'(m_af)));
    check("almost_empty", 32'(s_ae),    32'(m_lvl <= int'(m_ae)));
    check("rd_empty",     32'(s_empty), 32'(m_lvl == 0));
    check("overflow",     32'(s_ovf),   32'(m_ovf));
    check("underflow",    32'(s_unf),   32'(m_unf));
    check("rd_data",      32'(s_rd_data), 32'(m_rd));
  endtask

  // One clock of stimulus, then model update and full flag/data comparison of the standard instance.
  task automatic cycle(input logic we, input logic [3:0] d, input logic re,
                       input logic fl = 1'b0, input logic tw = 1'b0,
                       input logic [4:0] af = 5'd0, input logic [4:0] ae = 5'd0);
    bit wa, ra;
    wr_en = we; wr_data = d; rd_en = re; flush = fl;
    thr_we = tw; af_thr_in = af; ae_thr_in = ae;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; thr_we = 1'b0;
    if (fl) begin
      m_lvl = 0;
      sb.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      wa = we && (m_lvl < 16);
      ra = re && (m_lvl > 0);
      if (we && m_lvl == 16) m_ovf = 1'b1;
      if (re && m_lvl == 0)  m_unf = 1'b1;
      if (ra) m_rd = sb.pop_front();
      if (wa) sb.push_back(d);
      m_lvl = m_lvl + int'(wa) - int'(ra);
    end
    if (tw) begin
      m_af = af;
      m_ae = ae;
    end
    check_std();
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b0;
    #2;
    check_std();
    check("rst_f_empty", 32'(f_empty), 32'd1);
    check("rst_f_data",  32'(f_rd_data), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Fill to full, then one write too many.
    for (int i = 0; i < 13; i++) cycle(1'b1, 4'(i), 1'b0);
    check("af_below_14", 32'(s_af), 32'd0);
    cycle(1'b1, 4'd13, 1'b0);
    check("af_at_14", 32'(s_af), 32'd1);
    cycle(1'b1, 4'd14, 1'b0);
    cycle(1'b1, 4'd15, 1'b0);
    check("full_at_16", 32'(s_full), 32'd1);
    cycle(1'b1, 4'd9, 1'b0);
    check("ovf_set", 32'(s_ovf), 32'd1);
    check("lvl_after_ovf", 32'(s_level), 32'd16);

    // Drain, then one read too many.
    for (int i = 0; i < 16; i++) cycle(1'b0, 4'd0, 1'b1);
    cycle(1'b0, 4'd0, 1'b1);
    check("unf_set", 32'(s_unf), 32'd1);
    check("rd_hold", 32'(s_rd_data), 32'hF);

    // Level 8, then simultaneous push/pop across the pointer wrap.
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'(i + 1), 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 4'((i * 7 + 3) & 15), 1'b1);
    check("wrap_level", 32'(s_level), 32'd8);

    // Thresholds at level 5, then flush overriding concurrent requests.
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, 1'b1);
    cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd1);
    check("thr_af", 32'(s_af), 32'd1);
    check("thr_ae", 32'(s_ae), 32'd0);
    cycle(1'b1, 4'd7, 1'b1, 1'b1);
    check("flush_level", 32'(s_level), 32'd0);
    check("flush_empty", 32'(s_empty), 32'd1);
    check("flush_ovf",   32'(s_ovf), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i + 10), 1'b0);
    check("thr_kept_af", 32'(s_af), 32'd1);
    check("thr_kept_ae", 32'(s_ae), 32'd0);

    // Asynchronous reset in the middle of a write burst.
    cycle(1'b1, 4'd1, 1'b0);
    cycle(1'b1, 4'd2, 1'b0);
    wr_en = 1'b1; wr_data = 4'd3;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_std();
    check("mid_rst_f_empty", 32'(f_empty), 32'd1);
    check("mid_rst_f_data",  32'(f_rd_data), 32'd0);
    wr_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    cycle(1'b1, 4'd5, 1'b0);
    cycle(1'b0, 4'd0, 1'b1);
    check("post_rst_data", 32'(s_rd_data), 32'd5);
    cycle(1'b0, 4'd0, 1'b0, 1'b1);

    // FWFT latency: empty falls two cycles after the write, then one pop.
    cycle(1'b1, 4'hA, 1'b0);
    check("fwft_e0", 32'(f_empty), 32'd1);
    cycle(1'b0, 4'd0, 1'b0);
    check("fwft_e1", 32'(f_empty), 32'd1);
    cycle(1'b0, 4'd0, 1'b0);
    check("fwft_e2", 32'(f_empty), 32'd0);
    check("fwft_head", 32'(f_rd_data), 32'hA);
    cycle(1'b0, 4'd0, 1'b1);
    check("fwft_pop_empty", 32'(f_empty), 32'd1);

    // FWFT back-to-back pops with no bubble.
    cycle(1'b1, 4'hB, 1'b0);
    cycle(1'b1, 4'hC, 1'b0);
    cycle(1'b1, 4'hD, 1'b0);
    cycle(1'b0, 4'd0, 1'b0);
    check("fwft_b", 32'(f_rd_data), 32'hB);
    cycle(1'b0, 4'd0, 1'b1);
    check("fwft_c_valid", 32'(f_empty), 32'd0);
    check("fwft_c", 32'(f_rd_data), 32'hC);
    cycle(1'b0, 4'd0, 1'b1);
    check("fwft_d_valid", 32'(f_empty), 32'd0);
    check("fwft_d", 32'(f_rd_data), 32'hD);
    cycle(1'b0, 4'd0, 1'b1);
    check("fwft_drained", 32'(f_empty), 32'd1);
    check("fwft_level", 32'(f_level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
